// File: rtl/ccr_pkg.sv
// Shared definitions for the condition code register and the decoder that
// drives it: CCR bit positions, jump-condition encodings and ALU op numbering.
package ccr_pkg;

   localparam int CCR_W   = 4;

   // Fixed CCR bit positions.
   localparam int CCR_ZF  = 0;
   localparam int CCR_NF  = 1;
   localparam int CCR_CF  = 2;
   localparam int CCR_OVF = 3;

   // Flag tested by a conditional jump.
   typedef enum logic [1:0] {
      JC_Z    = 2'd0,
      JC_N    = 2'd1,
      JC_C    = 2'd2,
      JC_NONE = 2'd3
   } jmp_cond_e;

   // ALU operation numbering, shared with the decoder.
   typedef enum logic [3:0] {
      ALU_NOP = 4'd0,
      ALU_ADD = 4'd1,
      ALU_SUB = 4'd2,
      ALU_AND = 4'd3,
      ALU_OR  = 4'd4,
      ALU_XOR = 4'd5,
      ALU_NOT = 4'd6,
      ALU_SHL = 4'd7,
      ALU_SHR = 4'd8,
      ALU_INC = 4'd9,
      ALU_DEC = 4'd10,
      ALU_MOV = 4'd11,
      ALU_CMP = 4'd12
   } alu_op_e;

   // Flag write mask produced by the decoder for each ALU operation.
   function automatic logic [CCR_W-1:0] alu_op_upd_mask(input alu_op_e op);
      logic [CCR_W-1:0] m;
      m = '0;
      case (op)
         ALU_ADD, ALU_SUB, ALU_INC,
         ALU_DEC, ALU_CMP:                 m = 4'b1111;
         ALU_AND, ALU_OR, ALU_XOR,
         ALU_NOT, ALU_MOV:                 m = 4'b0011;
         ALU_SHL, ALU_SHR:                 m = 4'b0111;
         default:                          m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ccr_shadow.sv
// Single-level CCR shadow for interrupt entry / RTI, with a sticky nesting
// error flag raised on a save over a valid shadow, a restore from an empty
// shadow, or a save and restore in the same cycle.
module ccr_shadow
   import ccr_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             save,
   input  logic             restore,
   input  logic [CCR_W-1:0] ccr,
   output logic [CCR_W-1:0] shadow,
   output logic             shadow_valid,
   output logic             nest_err
);

   logic [CCR_W-1:0] shadow_q, shadow_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   // Next-state: restore wins over save; a same-cycle save is dropped.
   always_comb begin
      shadow_d = shadow_q;
      valid_d  = valid_q;
      err_d    = err_q;
      if (!stall) begin
         if (restore) begin
            valid_d = 1'b0;
            if (!valid_q || save) err_d = 1'b1;
         end else if (save) begin
            shadow_d = ccr;
            valid_d  = 1'b1;
            if (valid_q) err_d = 1'b1;
         end
      end
   end

   // Shadow, valid and sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign shadow       = shadow_q;
   assign shadow_valid = valid_q;
   assign nest_err     = err_q;

endmodule

// File: rtl/ccr_unit.sv
// Condition code register behind the ALU: masked flag latch, SETC/CLRC,
// clear of the tested flag on a taken conditional jump, and an interrupt
// shadow. Outputs are registered; an update in cycle N shows in cycle N+1.
module ccr_unit
   import ccr_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             alu_ZF,
   input  logic             alu_NF,
   input  logic             alu_CF,
   input  logic             alu_OVF,
   input  logic [CCR_W-1:0] upd_mask,
   input  logic             setc,
   input  logic             clrc,
   input  logic             jmp_taken,
   input  logic [1:0]       jmp_cond,
   input  logic             int_save,
   input  logic             rti_restore,
   output logic             ZF,
   output logic             NF,
   output logic             CF,
   output logic             OVF,
   output logic [CCR_W-1:0] ccr_out,
   output logic             shadow_valid,
   output logic             nest_err
);

   logic [CCR_W-1:0] ccr_q, ccr_d;
   logic [CCR_W-1:0] alu_flags;
   logic [CCR_W-1:0] shadow;

   assign alu_flags = {alu_OVF, alu_CF, alu_NF, alu_ZF};

   // Flag merge: stall holds, RTI reloads, else mask -> carry ops -> jump clear.
   always_comb begin
      ccr_d = ccr_q;
      if (stall) begin
         ccr_d = ccr_q;
      end else if (rti_restore) begin
         ccr_d = shadow;
      end else begin
         ccr_d = (ccr_q & ~upd_mask) | (alu_flags & upd_mask);
         if (setc)      ccr_d[CCR_CF] = 1'b1;
         else if (clrc) ccr_d[CCR_CF] = 1'b0;
         if (jmp_taken && (jmp_cond != JC_NONE)) ccr_d[jmp_cond] = 1'b0;
      end
   end

   // CCR state register.
   always_ff @(posedge clk) begin
      if (rst) ccr_q <= '0;
      else     ccr_q <= ccr_d;
   end

   ccr_shadow u_shadow (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .save         (int_save),
      .restore      (rti_restore),
      .ccr          (ccr_q),
      .shadow       (shadow),
      .shadow_valid (shadow_valid),
      .nest_err     (nest_err)
   );

   assign ZF      = ccr_q[CCR_ZF];
   assign NF      = ccr_q[CCR_NF];
   assign CF      = ccr_q[CCR_CF];
   assign OVF     = ccr_q[CCR_OVF];
   assign ccr_out = ccr_q;

endmodule
